// File: rtl/routing_unit_reg.sv
// routing_unit_reg: per-port registered route computation (XY, odd-even or west-first) with a valid/ack result hold.
// Latency: a request sampled at edge t is valid from cycle t+1; one result per cycle per port when ack and request coincide.
// Backpressure: the result is held until i_select_ack; a request arriving while a result is held is ignored and flagged on o_drop.

`ifndef N
`define N 5
`endif
`ifndef M
`define M 3
`endif
`ifndef X_NODES
`define X_NODES 5
`endif
`ifndef Y_NODES
`define Y_NODES 5
`endif

module routing_unit_reg #(
  parameter int X_LOC        = 0,
  parameter int Y_LOC        = 0,
  parameter int ROUTING_TYPE = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [0:`N-1]                               i_routing_calculate,
  input  logic [0:`N-1][$clog2(`X_NODES)-1:0]         i_x_source,
  input  logic [0:`N-1][$clog2(`X_NODES)-1:0]         i_x_dest,
  input  logic [0:`N-1][$clog2(`Y_NODES)-1:0]         i_y_dest,
  input  logic [0:`N-1]                               i_select_ack,
  output logic [0:`N-1]                               o_select_neighbor,
  output logic [0:`N-1][0:`M-1][1:0]                  o_avail_directions,
  output logic [0:`N-1]                               o_local,
  output logic [0:`N-1]                               o_route_err,
  output logic [0:`N-1]                               o_drop
);

  localparam int N  = `N;
  localparam int M  = `M;
  localparam int XW = $clog2(`X_NODES);
  localparam int YW = $clog2(`Y_NODES);

  localparam logic [XW-1:0] XL    = XW'(X_LOC);
  localparam logic [YW-1:0] YL    = YW'(Y_LOC);
  localparam logic [XW:0]   XL_P1 = (XW+1)'(X_LOC + 1);
  localparam logic [XW:0]   XN    = (XW+1)'(`X_NODES);
  localparam logic [YW:0]   YN    = (YW+1)'(`Y_NODES);

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef logic [0:M-1][1:0] slots_t;

  typedef struct packed {
    slots_t slots;
    logic   loc;
    logic   err;
  } route_t;

  typedef enum logic {IDLE, VALID} state_t;

  // Minimal candidate list for one head flit; directions fill slots from 0, last slot holds the count.
  function automatic route_t calc(input logic [XW-1:0] xs,
                                  input logic [XW-1:0] xd,
                                  input logic [YW-1:0] yd);
    route_t     r;
    logic [1:0] cnt;
    logic       east;
    logic       west;
    logic       vert;
    logic [1:0] ns;
    r    = '0;
    cnt  = '0;
    east = (xd > XL);
    west = (xd < XL);
    vert = (yd != YL);
    ns   = (yd > YL) ? DIR_N : DIR_S;
    if (({1'b0, xd} >= XN) || ({1'b0, yd} >= YN)) begin
      r.err = 1'b1;
    end else if (!east && !west && !vert) begin
      r.loc = 1'b1;
    end else if (ROUTING_TYPE == 2) begin
      if (east) begin
        // Vertical turn allowed here only in odd columns or in the source column.
        if (vert && (XL[0] || (xs == XL))) begin
          r.slots[cnt] = ns;
          cnt = cnt + 2'd1;
        end
        // Keep going east unless that would land on an even destination column still needing a vertical turn.
        if (!vert || xd[0] || ({1'b0, xd} != XL_P1)) begin
          r.slots[cnt] = DIR_E;
          cnt = cnt + 2'd1;
        end
      end else if (west) begin
        r.slots[cnt] = DIR_W;
        cnt = cnt + 2'd1;
        if (!XL[0] && vert) begin
          r.slots[cnt] = ns;
          cnt = cnt + 2'd1;
        end
      end else begin
        r.slots[cnt] = ns;
        cnt = cnt + 2'd1;
      end
    end else if (ROUTING_TYPE == 3) begin
      if (west) begin
        r.slots[cnt] = DIR_W;
        cnt = cnt + 2'd1;
      end else if (east) begin
        r.slots[cnt] = DIR_E;
        cnt = cnt + 2'd1;
        if (vert) begin
          r.slots[cnt] = ns;
          cnt = cnt + 2'd1;
        end
      end else begin
        r.slots[cnt] = ns;
        cnt = cnt + 2'd1;
      end
    end else begin
      if (east) begin
        r.slots[cnt] = DIR_E;
      end else if (west) begin
        r.slots[cnt] = DIR_W;
      end else begin
        r.slots[cnt] = ns;
      end
      cnt = cnt + 2'd1;
    end
    r.slots[M-1] = cnt;
    return r;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_port
    state_t state;
    logic   sel_q;
    logic   loc_q;
    logic   err_q;
    logic   drop_q;
    slots_t slots_q;
    route_t nxt;

    assign nxt = calc(i_x_source[g], i_x_dest[g], i_y_dest[g]);

    // Per-port handshake FSM; result registers load only when a request is accepted.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        sel_q   <= 1'b0;
        loc_q   <= 1'b0;
        err_q   <= 1'b0;
        drop_q  <= 1'b0;
        slots_q <= '0;
      end else begin
        drop_q <= 1'b0;
        case (state)
          IDLE: begin
            if (i_routing_calculate[g]) begin
              state   <= VALID;
              sel_q   <= 1'b1;
              slots_q <= nxt.slots;
              loc_q   <= nxt.loc;
              err_q   <= nxt.err;
            end
          end
          VALID: begin
            if (i_select_ack[g]) begin
              if (i_routing_calculate[g]) begin
                slots_q <= nxt.slots;
                loc_q   <= nxt.loc;
                err_q   <= nxt.err;
              end else begin
                state <= IDLE;
                sel_q <= 1'b0;
              end
            end else if (i_routing_calculate[g]) begin
              drop_q <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            sel_q <= 1'b0;
          end
        endcase
      end
    end

    assign o_select_neighbor[g]  = sel_q;
    assign o_avail_directions[g] = slots_q;
    assign o_local[g]            = loc_q;
    assign o_route_err[g]        = err_q;
    assign o_drop[g]             = drop_q;
  end

endmodule

// File: tb/tb_routing_unit_reg.sv
// Testbench for routing_unit_reg: five instances at different locations/algorithms share one randomized stimulus.
// A behavioural model (signed dx/dy and a direction queue) is compared every negedge; directed literals pin the model.
// Runs a directed sequence from the test plan followed by a randomized phase with occasional resets.

`timescale 1ns/1ps

`ifndef N
`define N 5
`endif
`ifndef M
`define M 3
`endif
`ifndef X_NODES
`define X_NODES 5
`endif
`ifndef Y_NODES
`define Y_NODES 5
`endif

module tb_routing_unit_reg;

  localparam int N  = `N;
  localparam int M  = `M;
  localparam int XW = $clog2(`X_NODES);
  localparam int YW = $clog2(`Y_NODES);
  localparam int SW = 2 * `M;
  localparam int NI = 5;

  localparam int XLS [NI] = '{1, 1, 2, 2, 3};
  localparam int YLS [NI] = '{1, 1, 1, 2, 3};
  localparam int RTS [NI] = '{1, 2, 2, 3, 7};

  typedef struct packed {
    logic [SW-1:0] s;
    logic          loc;
    logic          err;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic run = 1'b0;
  always #5 clk = ~clk;

  logic [0:N-1]         rq;
  logic [0:N-1]         ak;
  logic [0:N-1][XW-1:0] xs;
  logic [0:N-1][XW-1:0] xd;
  logic [0:N-1][YW-1:0] yd;

  logic [0:N-1]              sel  [NI];
  logic [0:N-1]              loc  [NI];
  logic [0:N-1]              err  [NI];
  logic [0:N-1]              drop [NI];
  logic [0:N-1][0:M-1][1:0]  dirs [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    routing_unit_reg #(
      .X_LOC(XLS[k]),
      .Y_LOC(YLS[k]),
      .ROUTING_TYPE(RTS[k])
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .i_routing_calculate(rq),
      .i_x_source(xs),
      .i_x_dest(xd),
      .i_y_dest(yd),
      .i_select_ack(ak),
      .o_select_neighbor(sel[k]),
      .o_avail_directions(dirs[k]),
      .o_local(loc[k]),
      .o_route_err(err[k]),
      .o_drop(drop[k])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int k, input int p, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d port=%0d: got %0h, expected %0h at %0t", nm, k, p, act, exp, $time);
    end
  endtask

  // Reference routing from the algorithm rules using signed offsets and a direction queue.
  function automatic res_t route(input int k, input logic [XW-1:0] s, input logic [XW-1:0] x, input logic [YW-1:0] y);
    res_t r;
    int   dx;
    int   dy;
    int   ns;
    int   q[$];
    r  = '0;
    dx = int'(x) - XLS[k];
    dy = int'(y) - YLS[k];
    ns = (dy > 0) ? 0 : 2;
    if (int'(x) >= `X_NODES || int'(y) >= `Y_NODES) begin
      r.err = 1'b1;
    end else if (dx == 0 && dy == 0) begin
      r.loc = 1'b1;
    end else if (RTS[k] == 2) begin
      if (dx == 0) q.push_back(ns);
      else if (dx > 0) begin
        if (dy == 0) q.push_back(1);
        else begin
          if ((XLS[k] % 2 == 1) || (XLS[k] == int'(s))) q.push_back(ns);
          if (x[0] || dx != 1) q.push_back(1);
        end
      end else begin
        q.push_back(3);
        if ((XLS[k] % 2 == 0) && dy != 0) q.push_back(ns);
      end
    end else if (RTS[k] == 3) begin
      if (dx < 0) q.push_back(3);
      else if (dx > 0) begin
        q.push_back(1);
        if (dy != 0) q.push_back(ns);
      end else q.push_back(ns);
    end else begin
      if (dx > 0) q.push_back(1);
      else if (dx < 0) q.push_back(3);
      else q.push_back(ns);
    end
    for (int i = 0; i < q.size(); i++) r.s[SW-1-2*i -: 2] = 2'(q[i]);
    r.s[1:0] = 2'(q.size());
    return r;
  endfunction

  function automatic logic [SW-1:0] sl(input int a, input int b, input int c);
    return {2'(a), 2'(b), 2'(c)};
  endfunction

  logic mv    [NI][N];
  logic mdrop [NI][N];
  res_t mres  [NI][N];

  // Model state: a port accepts a request when free or freed by an ack in the same cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NI; k++)
        for (int p = 0; p < N; p++) begin
          mv[k][p]    <= 1'b0;
          mdrop[k][p] <= 1'b0;
          mres[k][p]  <= '0;
        end
    end else begin
      for (int k = 0; k < NI; k++)
        for (int p = 0; p < N; p++) begin
          mdrop[k][p] <= 1'b0;
          if (rq[p] && (!mv[k][p] || ak[p])) begin
            mv[k][p]   <= 1'b1;
            mres[k][p] <= route(k, xs[p], xd[p], yd[p]);
          end else if (ak[p] && mv[k][p]) begin
            mv[k][p] <= 1'b0;
          end else if (rq[p]) begin
            mdrop[k][p] <= 1'b1;
          end
        end
    end
  end

  // Cycle-by-cycle comparison of every instance and port against the model.
  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < NI; k++)
        for (int p = 0; p < N; p++) begin
          chk("sel", k, p, 32'(sel[k][p]), 32'(mv[k][p]));
          chk("drop", k, p, 32'(drop[k][p]), 32'(mdrop[k][p]));
          if (mv[k][p]) begin
            chk("dirs", k, p, 32'(dirs[k][p]), 32'(mres[k][p].s));
            chk("local", k, p, 32'(loc[k][p]), 32'(mres[k][p].loc));
            chk("route_err", k, p, 32'(err[k][p]), 32'(mres[k][p].err));
          end
        end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rq = '0;
    ak = '0;
  endtask

  task automatic setreq(input int p, input int s, input int x, input int y);
    rq[p] = 1'b1;
    xs[p] = XW'(s);
    xd[p] = XW'(x);
    yd[p] = YW'(y);
  endtask

  initial begin
    rq = '0; ak = '0; xs = '0; xd = '0; yd = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    run = 1'b1;

    // Model pinned against hand-computed lists.
    chk("model_xy", 0, 0, 32'(route(0, 3'd0, 3'd3, 3'd2).s), 32'(sl(1, 0, 1)));
    chk("model_oe", 1, 0, 32'(route(1, 3'd0, 3'd3, 3'd2).s), 32'(sl(0, 1, 2)));
    chk("model_oe_w", 2, 0, 32'(route(2, 3'd0, 3'd0, 3'd0).s), 32'(sl(3, 2, 2)));
    chk("model_wf", 3, 0, 32'(route(3, 3'd0, 3'd4, 3'd0).s), 32'(sl(1, 2, 2)));
    chk("model_err", 0, 0, 32'(route(0, 3'd0, 3'd6, 3'd1)), 32'({sl(0, 0, 0), 1'b0, 1'b1}));

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_sel", k, 0, 32'(sel[k]), 32'd0);
      chk("rst_dirs", k, 0, 32'(dirs[k]), 32'd0);
      chk("rst_flags", k, 0, 32'({loc[k], err[k], drop[k]}), 32'd0);
    end
    @(posedge clk); #1 reset = 1'b0;

    setreq(0, 0, 3, 2); step; @(negedge clk);
    chk("xy_3_2", 0, 0, 32'(dirs[0][0]), 32'(sl(1, 0, 1)));
    chk("oe11_3_2", 1, 0, 32'(dirs[1][0]), 32'(sl(0, 1, 2)));
    chk("oe21_3_2", 2, 0, 32'(dirs[2][0]), 32'(sl(1, 0, 1)));
    chk("wf22_3_2", 3, 0, 32'(dirs[3][0]), 32'(sl(1, 0, 1)));
    chk("dflt33_3_2", 4, 0, 32'(dirs[4][0]), 32'(sl(2, 0, 1)));
    chk("valid_t1", 0, 0, 32'(sel[0][0]), 32'd1);

    // Asynchronous reset while holding a result.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_sel", 0, 0, 32'(sel[0][0]), 32'd0);
    chk("async_rst_dirs", 1, 0, 32'(dirs[1][0]), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    setreq(0, 0, 1, 0); step; @(negedge clk);
    chk("post_rst_sel", 0, 0, 32'(sel[0][0]), 32'd1);
    chk("xy_1_0", 0, 0, 32'(dirs[0][0]), 32'(sl(2, 0, 1)));

    setreq(0, 0, 1, 1); ak[0] = 1'b1; step; @(negedge clk);
    chk("xy_local", 0, 0, 32'(loc[0][0]), 32'd1);
    chk("xy_local_cnt", 0, 0, 32'(dirs[0][0]), 32'(sl(0, 0, 0)));

    ak[0] = 1'b1; step; @(negedge clk);
    chk("ack_clear", 0, 0, 32'(sel[0][0]), 32'd0);

    setreq(2, 0, 0, 0); step; @(negedge clk);
    chk("oe21_0_0", 2, 2, 32'(dirs[2][2]), 32'(sl(3, 2, 2)));
    chk("wf22_0_0", 3, 2, 32'(dirs[3][2]), 32'(sl(3, 0, 1)));

    setreq(3, 0, 0, 4); setreq(4, 0, 4, 0); step; @(negedge clk);
    chk("wf22_0_4", 3, 3, 32'(dirs[3][3]), 32'(sl(3, 0, 1)));
    chk("wf22_4_0", 3, 4, 32'(dirs[3][4]), 32'(sl(1, 2, 2)));

    // Handshake on port 1.
    setreq(1, 0, 3, 2); step; @(negedge clk);
    chk("hs_valid", 0, 1, 32'(sel[0][1]), 32'd1);
    step;
    setreq(1, 0, 1, 0); step; @(negedge clk);
    chk("hs_drop", 0, 1, 32'(drop[0][1]), 32'd1);
    chk("hs_held", 0, 1, 32'(dirs[0][1]), 32'(sl(1, 0, 1)));
    ak[1] = 1'b1; step; @(negedge clk);
    chk("hs_clear", 0, 1, 32'(sel[0][1]), 32'd0);
    chk("hs_drop_once", 0, 1, 32'(drop[0][1]), 32'd0);
    setreq(1, 0, 3, 2); step;
    setreq(1, 0, 1, 0); ak[1] = 1'b1; step; @(negedge clk);
    chk("hs_reload_sel", 0, 1, 32'(sel[0][1]), 32'd1);
    chk("hs_reload", 0, 1, 32'(dirs[0][1]), 32'(sl(2, 0, 1)));

    setreq(2, 0, 6, 1); ak[2] = 1'b1; step; @(negedge clk);
    chk("err_flag", 0, 2, 32'(err[0][2]), 32'd1);
    chk("err_cnt", 0, 2, 32'(dirs[0][2]), 32'd0);
    chk("err_valid", 0, 2, 32'(sel[0][2]), 32'd1);

    for (int p = 0; p < N; p++) setreq(p, p, p, 4 - p);
    ak = '1; step; @(negedge clk);
    for (int k = 0; k < NI; k++) chk("all_valid", k, 0, 32'(sel[k]), 32'h1f);
    chk("conc_p0", 0, 0, 32'(dirs[0][0]), 32'(sl(3, 0, 1)));
    chk("conc_p4", 0, 4, 32'(dirs[0][4]), 32'(sl(1, 0, 1)));
    ak = '1; step;

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 249) == 0);
      for (int p = 0; p < N; p++) begin
        rq[p] = ($urandom_range(0, 99) < 45);
        ak[p] = ($urandom_range(0, 99) < 50);
        xs[p] = XW'($urandom_range(0, 4));
        xd[p] = XW'(($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4));
        yd[p] = YW'(($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4));
      end
      step;
    end
    reset = 1'b0;
    step;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
